obi_cache_cmdq_interface: RTL and testbench
===========================================

Name: obi_cache_cmdq_interface

Overview:
- Next-generation OBI slave front end for the key/value cache controller.
- Adds a parametrised command queue of CMD_DEPTH entries, so the CPU can post several operations without waiting for each one to finish.
- Adds a memory-mapped status word, a separate read-only result window, and per-byte write enables.
- Sits between the CPU's OBI port and the cache controller; it replaces the single-request interface.

Parameters:
- ARCHITECTURE, 32: OBI data width in bits; must be 32 or 64.
- ID_WIDTH, 3: width of the OBI transaction ID.
- KEY_WIDTH, 32: key width; must be a multiple of ARCHITECTURE.
- VALUE_WIDTH, 64: value width; must be a multiple of ARCHITECTURE.
- OP_WIDTH, 3: operation code width; code 0 is NOOP.
- CMD_DEPTH, 4: number of command queue entries; must be ≥2 and a power of two.
- ADDR_WIDTH, 8: width of the OBI byte address.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- req_i  in  1  OBI request
- gnt_o  out  1  OBI grant
- addr_i  in  ADDR_WIDTH  OBI byte address
- we_i  in  1  1 = write, 0 = read
- be_i  in  ARCHITECTURE/8  byte enables
- wdata_i  in  ARCHITECTURE  write data
- aid_i  in  ID_WIDTH  request ID
- rvalid_o  out  1  response valid
- rdata_o  out  ARCHITECTURE  read data
- rid_o  out  ID_WIDTH  response ID, equal to the aid of the granted request
- err_o  out  1  response error
- cmd_valid_out  out  1  queue head is valid
- operation_out  out  OP_WIDTH  head operation; NOOP when the queue is empty
- key_out  out  KEY_WIDTH  head key
- value_out  out  VALUE_WIDTH  head value
- ready_in  in  1  controller completion pulse; completes the head entry
- op_succ_in  in  1  operation succeeded, qualified by ready_in
- value_in  in  VALUE_WIDTH  result value, qualified by ready_in

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: all outputs are 0 and operation_out is NOOP. The queue is flushed and the staging, result and status registers are cleared. Any pending response is dropped. Reset asserted mid-operation behaves identically.
- Address decode: word index = addr_i >> log2(ARCHITECTURE/8). Low address bits are ignored. Define VW = VALUE_WIDTH/ARCHITECTURE and KW = KEY_WIDTH/ARCHITECTURE.
- Word map:
  - Words 0..VW-1: value staging, read/write; word 0 holds the least significant bits.
  - Words VW..VW+KW-1: key staging, read/write.
  - Word OP = VW+KW: operation commit, write-only; reads return 0.
  - Word OP+1: status, read-only.
  - Words OP+2..OP+1+VW: result value, read-only.
  - Any other index, or a write to a read-only word, returns err_o=1. Such a write has no side effect.
- Staging writes: only bytes whose be_i bit is set are updated. Staging contents persist after a commit.
- Commit: a write to OP with wdata_i[OP_WIDTH-1:0] != 0 pushes {op, key staging, value staging} onto the queue. A commit of op 0 (NOOP) is accepted and does nothing.
- Grant: gnt_o = req_i in the same cycle, except that gnt_o = 0 when the request is a write to OP and the queue is full. Full is the registered state; a same-cycle pop does not free a slot. While gnt_o is low the master holds its request.
- Response:
  - Timing: rvalid_o is high exactly one cycle after each granted request, with rid_o = aid_i of that request.
  - rdata_o: for reads, the value sampled from the register state at the grant edge, before that edge's updates. For writes, rdata_o = 0.
  - No back-pressure: one response is produced per grant, and back-to-back grants are allowed.
- Controller side:
  - cmd_valid_out = (count > 0). The head fields are stable while cmd_valid_out is high.
  - ready_in while cmd_valid_out is high pops the head, latches value_in into the result register, sets last_err = ~op_succ_in, sets result_valid, and increments done_cnt (8 bits, wraps from 255 to 0).
  - ready_in while the queue is empty is ignored.
  - A push and a pop in the same cycle leave count unchanged. Read and write pointers wrap modulo CMD_DEPTH.
- Status word:
  - bit 0: busy (count > 0)
  - bit 1: full
  - bit 2: last_err
  - bit 3: result_valid
  - bits 7:4: count, zero-extended
  - bits 15:8: done_cnt
  - all other bits read 0
- result_valid clear: cleared by a granted read of result word OP+2. If a completion occurs in the same cycle, the completion wins and result_valid stays 1.

Test Plan:
1. Reset, then read the status word -> rdata 0, err 0, rvalid one cycle after gnt, rid = aid.
2. Write value words 0x11111111 and 0x22222222 and key 0xABCD, then commit op 1 -> cmd_valid_out=1, operation_out=1, key_out=0xABCD, value_out=0x2222222211111111. Then pulse ready_in with op_succ_in=1 and value_in=0x5 -> result word reads 5, status reads 0x0108 (done_cnt=1, result_valid=1).
3. Commit 4 ops with CMD_DEPTH=4 and no ready_in -> status reads full=1, count=4; a fifth commit holds gnt_o=0 until one ready_in pulse, after which it is granted the next cycle.
4. Write be_i=4'b0010 with data 0xFFFFFFFF to value word 0 after writing 0 -> readback is 0x0000FF00.
5. Read an unmapped index and write the status word -> err_o=1 on both responses; status is unchanged.
6. Pulse ready_in with op_succ_in=0 -> last_err=1. Read result word 0 in the same cycle as a second completion -> old value returned and result_valid remains 1. Assert rst_n low with 2 entries queued -> cmd_valid_out=0 and all registers read 0.

Source files
------------

// File: rtl/obi_cache_cmdq_interface.sv
`default_nettype none
// ============================================================================
// Module   : obi_cache_cmdq_interface
// Purpose  : OBI slave front end for the key/value cache controller. The CPU
//            stages a key and value through memory-mapped words, then posts
//            operations into a CMD_DEPTH-entry command queue. It reads back
//            status and the last completed result through read-only words.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            req_i..aid_i      - OBI request channel (gnt_o is combinational)
//            rvalid_o..err_o   - OBI response, one cycle after each grant
//            cmd_valid_out, operation_out, key_out, value_out
//                              - queue head presented to the controller
//            ready_in, op_succ_in, value_in
//                              - controller completion of the head entry
// Revision : 1.0 - initial release
// ============================================================================
module obi_cache_cmdq_interface #(
  parameter int ARCHITECTURE = 32,
  parameter int ID_WIDTH     = 3,
  parameter int KEY_WIDTH    = 32,
  parameter int VALUE_WIDTH  = 64,
  parameter int OP_WIDTH     = 3,
  parameter int CMD_DEPTH    = 4,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic                      we_i,
  input  logic [ARCHITECTURE/8-1:0] be_i,
  input  logic [ARCHITECTURE-1:0]   wdata_i,
  input  logic [ID_WIDTH-1:0]       aid_i,
  output logic                      rvalid_o,
  output logic [ARCHITECTURE-1:0]   rdata_o,
  output logic [ID_WIDTH-1:0]       rid_o,
  output logic                      err_o,
  output logic                      cmd_valid_out,
  output logic [OP_WIDTH-1:0]       operation_out,
  output logic [KEY_WIDTH-1:0]      key_out,
  output logic [VALUE_WIDTH-1:0]    value_out,
  input  logic                      ready_in,
  input  logic                      op_succ_in,
  input  logic [VALUE_WIDTH-1:0]    value_in
);

  localparam int c_bytes = ARCHITECTURE / 8;
  localparam int c_lsb   = $clog2(c_bytes);
  localparam int c_vw    = VALUE_WIDTH / ARCHITECTURE;
  localparam int c_kw    = KEY_WIDTH / ARCHITECTURE;
  localparam int c_op    = c_vw + c_kw;
  localparam int c_stat  = c_op + 1;
  localparam int c_res   = c_op + 2;
  localparam int c_pw    = $clog2(CMD_DEPTH);
  localparam logic [c_pw:0] c_depth = CMD_DEPTH[c_pw:0];

  logic [VALUE_WIDTH-1:0]  r_value;
  logic [KEY_WIDTH-1:0]    r_key;
  logic [VALUE_WIDTH-1:0]  r_result;
  logic                    r_result_valid;
  logic                    r_last_err;
  logic [7:0]              r_done_cnt;
  logic [c_pw-1:0]         r_wptr;
  logic [c_pw-1:0]         r_rptr;
  logic [c_pw:0]           r_count;
  logic [OP_WIDTH-1:0]     r_q_op  [CMD_DEPTH];
  logic [KEY_WIDTH-1:0]    r_q_key [CMD_DEPTH];
  logic [VALUE_WIDTH-1:0]  r_q_val [CMD_DEPTH];

  logic                    r_rvalid;
  logic [ARCHITECTURE-1:0] r_rdata;
  logic [ID_WIDTH-1:0]     r_rid;
  logic                    r_err;

  logic [31:0]             w_word;
  logic                    w_full;
  logic                    w_is_op;
  logic                    w_wr;
  logic                    w_rd;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_rd_ok;
  logic                    w_wr_ok;
  logic                    w_err;
  logic [ARCHITECTURE-1:0] w_rword;
  logic [ARCHITECTURE-1:0] w_status;
  logic                    w_unused_addr;

  // Sub-word address bits carry no information for word-granular registers.
  assign w_unused_addr = ^addr_i[c_lsb-1:0];
  assign w_word        = 32'(addr_i >> c_lsb);

  assign w_full  = (r_count == c_depth);
  assign w_is_op = (w_word == c_op);
  // Only a commit against a full queue is stalled; full is the registered
  // state, so a pop in the same cycle does not open a slot early.
  assign gnt_o   = req_i & ~(we_i & w_is_op & w_full);
  assign w_wr    = gnt_o & we_i;
  assign w_rd    = gnt_o & ~we_i;
  assign w_push  = w_wr & w_is_op & (wdata_i[OP_WIDTH-1:0] != '0);
  assign w_pop   = ready_in & (r_count != '0);

  always_comb begin
    w_status        = '0;
    w_status[0]     = (r_count != '0);
    w_status[1]     = w_full;
    w_status[2]     = r_last_err;
    w_status[3]     = r_result_valid;
    w_status[7:4]   = 4'(r_count);
    w_status[15:8]  = r_done_cnt;
  end

  // Read mux and access legality for the addressed word.
  always_comb begin
    w_rword = '0;
    w_rd_ok = 1'b0;
    w_wr_ok = 1'b0;
    for (int w = 0; w < c_vw; w++) begin
      if (w_word == w) begin
        w_rword = r_value[w*ARCHITECTURE +: ARCHITECTURE];
        w_rd_ok = 1'b1;
        w_wr_ok = 1'b1;
      end
    end
    for (int k = 0; k < c_kw; k++) begin
      if (w_word == c_vw + k) begin
        w_rword = r_key[k*ARCHITECTURE +: ARCHITECTURE];
        w_rd_ok = 1'b1;
        w_wr_ok = 1'b1;
      end
    end
    if (w_is_op) begin
      w_rd_ok = 1'b1;
      w_wr_ok = 1'b1;
    end
    if (w_word == c_stat) begin
      w_rword = w_status;
      w_rd_ok = 1'b1;
    end
    for (int r = 0; r < c_vw; r++) begin
      if (w_word == c_res + r) begin
        w_rword = r_result[r*ARCHITECTURE +: ARCHITECTURE];
        w_rd_ok = 1'b1;
      end
    end
  end

  assign w_err = we_i ? ~w_wr_ok : ~w_rd_ok;

  // Response channel, plus staging, result and status state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid       <= 1'b0;
      r_rdata        <= '0;
      r_rid          <= '0;
      r_err          <= 1'b0;
      r_value        <= '0;
      r_key          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_last_err     <= 1'b0;
      r_done_cnt     <= '0;
    end else begin
      r_rvalid <= gnt_o;
      r_rid    <= gnt_o ? aid_i : '0;
      r_err    <= gnt_o & w_err;
      r_rdata  <= (w_rd && !w_err) ? w_rword : '0;

      // Non-staging indices never match these loops, so illegal writes
      // leave the staging registers untouched.
      for (int w = 0; w < c_vw; w++) begin
        for (int b = 0; b < c_bytes; b++) begin
          if (w_wr && (w_word == w) && be_i[b])
            r_value[w*ARCHITECTURE + b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
      for (int k = 0; k < c_kw; k++) begin
        for (int b = 0; b < c_bytes; b++) begin
          if (w_wr && (w_word == c_vw + k) && be_i[b])
            r_key[k*ARCHITECTURE + b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end

      // A completion outranks the read-to-clear of the result word.
      if (w_pop) begin
        r_result       <= value_in;
        r_last_err     <= ~op_succ_in;
        r_result_valid <= 1'b1;
        r_done_cnt     <= r_done_cnt + 8'd1;
      end else if (w_rd && (w_word == c_res)) begin
        r_result_valid <= 1'b0;
      end
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Queue storage needs no reset: the head is masked whenever count is 0.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_op[r_wptr]  <= wdata_i[OP_WIDTH-1:0];
      r_q_key[r_wptr] <= r_key;
      r_q_val[r_wptr] <= r_value;
    end
  end

  assign cmd_valid_out = (r_count != '0);
  assign operation_out = cmd_valid_out ? r_q_op[r_rptr]  : '0;
  assign key_out       = cmd_valid_out ? r_q_key[r_rptr] : '0;
  assign value_out     = cmd_valid_out ? r_q_val[r_rptr] : '0;

  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign rid_o    = r_rid;
  assign err_o    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_obi_cache_cmdq_interface.sv
`default_nettype none
// ============================================================================
// Module   : tb_obi_cache_cmdq_interface
// Purpose  : Directed self-checking bench for obi_cache_cmdq_interface with
//            default parameters (32-bit bus, 2 value words, 1 key word).
//            Word map: 0-1 value, 2 key, 3 commit, 4 status, 5-6 result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_obi_cache_cmdq_interface;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        gnt_o;
  logic [7:0]  addr_i = '0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = '0;
  logic [31:0] wdata_i = '0;
  logic [2:0]  aid_i = '0;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic [2:0]  rid_o;
  logic        err_o;
  logic        cmd_valid_out;
  logic [2:0]  operation_out;
  logic [31:0] key_out;
  logic [63:0] value_out;
  logic        ready_in = 1'b0;
  logic        op_succ_in = 1'b0;
  logic [63:0] value_in = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd;
  logic        er;
  logic        rv;
  logic [2:0]  ri;

  obi_cache_cmdq_interface dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .aid_i(aid_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rid_o(rid_o), .err_o(err_o),
    .cmd_valid_out(cmd_valid_out), .operation_out(operation_out),
    .key_out(key_out), .value_out(value_out), .ready_in(ready_in),
    .op_succ_in(op_succ_in), .value_in(value_in)
  );

  always #5 clk = ~clk;

  // One OBI transfer; waits (bounded) for grant, returns the response.
  task automatic bus(input logic we, input int word, input logic [31:0] data,
                     input logic [3:0] be, input logic [2:0] id,
                     output logic [31:0] o_rd, output logic o_er,
                     output logic o_rv, output logic [2:0] o_ri);
    int n;
    n = 0;
    @(negedge clk);
    req_i = 1'b1; we_i = we; addr_i = 8'(word * 4); wdata_i = data;
    be_i = be; aid_i = id;
    #1;
    while (!gnt_o && n < 40) begin
      @(negedge clk); #1; n++;
    end
    if (!gnt_o) begin
      checks++; errors++;
      $display("FAIL bus_grant_timeout word=%0d got gnt=0 expected 1", word);
      req_i = 1'b0;
      o_rd = 'x; o_er = 1'bx; o_rv = 1'b0; o_ri = 'x;
    end else begin
      @(posedge clk); #1;
      req_i = 1'b0; we_i = 1'b0;
      o_rd = rdata_o; o_er = err_o; o_rv = rvalid_o; o_ri = rid_o;
    end
  endtask

  task automatic complete(input logic succ, input logic [63:0] val);
    @(negedge clk);
    ready_in = 1'b1; op_succ_in = succ; value_in = val;
    @(negedge clk);
    ready_in = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (cmd_valid_out !== 1'b0 || operation_out !== 3'd0 || rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b op=%0d rvalid=%b expected 0 0 0",
               cmd_valid_out, operation_out, rvalid_o);
    end
    bus(1'b0, 4, 0, 4'hF, 3'd5, rd, er, rv, ri);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0 || rv !== 1'b1 || ri !== 3'd5) begin
      errors++;
      $display("FAIL reset_status got rdata=%h err=%b rvalid=%b rid=%0d expected 0 0 1 5",
               rd, er, rv, ri);
    end
  endtask

  task automatic test_commit();
    bus(1'b1, 0, 32'h11111111, 4'hF, 3'd1, rd, er, rv, ri);
    bus(1'b1, 1, 32'h22222222, 4'hF, 3'd2, rd, er, rv, ri);
    bus(1'b1, 2, 32'h0000ABCD, 4'hF, 3'd3, rd, er, rv, ri);
    bus(1'b1, 3, 32'h1, 4'hF, 3'd4, rd, er, rv, ri);
    checks++;
    if (rv !== 1'b1 || ri !== 3'd4 || er !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL commit_resp got rvalid=%b rid=%0d err=%b rdata=%h expected 1 4 0 0",
               rv, ri, er, rd);
    end
    checks++;
    if (cmd_valid_out !== 1'b1 || operation_out !== 3'd1 || key_out !== 32'hABCD ||
        value_out !== 64'h2222222211111111) begin
      errors++;
      $display("FAIL commit_head got v=%b op=%0d key=%h val=%h expected 1 1 abcd 2222222211111111",
               cmd_valid_out, operation_out, key_out, value_out);
    end
    bus(1'b0, 4, 0, 4'hF, 3'd0, rd, er, rv, ri);
    checks++;
    if (rd !== 32'h11) begin
      errors++;
      $display("FAIL commit_status got %h expected 00000011", rd);
    end
    complete(1'b1, 64'h5);
    bus(1'b0, 4, 0, 4'hF, 3'd0, rd, er, rv, ri);
    checks++;
    if (rd !== 32'h0108) begin
      errors++;
      $display("FAIL done_status got %h expected 00000108", rd);
    end
    bus(1'b0, 5, 0, 4'hF, 3'd6, rd, er, rv, ri);
    checks++;
    if (rd !== 32'h5 || er !== 1'b0 || ri !== 3'd6) begin
      errors++;
      $display("FAIL result_read got rdata=%h err=%b rid=%0d expected 5 0 6", rd, er, ri);
    end
    bus(1'b0, 4, 0, 4'hF, 3'd0, rd, er, rv, ri);
    checks++;
    if (rd !== 32'h0100) begin
      errors++;
      $display("FAIL result_valid_clear got %h expected 00000100", rd);
    end
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) bus(1'b1, 3, 32'(i), 4'hF, 3'd0, rd, er, rv, ri);
    bus(1'b0, 4, 0, 4'hF, 3'd0, rd, er, rv, ri);
    checks++;
    if (rd !== 32'h0143) begin
      errors++;
      $display("FAIL full_status got %h expected 00000143", rd);
    end
    // Fifth commit stalls until a completion has freed a slot.
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = 8'd12; wdata_i = 32'd5; be_i = 4'hF; aid_i = 3'd7;
    #1;
    checks++;
    if (gnt_o !== 1'b0) begin
      errors++; $display("FAIL full_stall got gnt=%b expected 0", gnt_o);
    end
    @(negedge clk);
    ready_in = 1'b1; op_succ_in = 1'b1; value_in = 64'h77;
    #1;
    checks++;
    if (gnt_o !== 1'b0) begin
      errors++; $display("FAIL full_same_cycle_pop got gnt=%b expected 0", gnt_o);
    end
    @(negedge clk);
    ready_in = 1'b0;
    #1;
    checks++;
    if (gnt_o !== 1'b1) begin
      errors++; $display("FAIL full_regrant got gnt=%b expected 1", gnt_o);
    end
    @(posedge clk); #1;
    req_i = 1'b0; we_i = 1'b0;
    checks++;
    if (rvalid_o !== 1'b1 || rid_o !== 3'd7 || operation_out !== 3'd2) begin
      errors++;
      $display("FAIL full_push_resp got rvalid=%b rid=%0d head=%0d expected 1 7 2",
               rvalid_o, rid_o, operation_out);
    end
    bus(1'b0, 4, 0, 4'hF, 3'd0, rd, er, rv, ri);
    checks++;
    if (rd !== 32'h024B) begin
      errors++;
      $display("FAIL full_status2 got %h expected 0000024b", rd);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (operation_out !== 3'(i + 2)) begin
        errors++;
        $display("FAIL drain_order got op=%0d expected %0d", operation_out, i + 2);
      end
      complete(1'b1, 64'(100 + i));
    end
    bus(1'b0, 4, 0, 4'hF, 3'd0, rd, er, rv, ri);
    checks++;
    if (rd !== 32'h0608) begin
      errors++;
      $display("FAIL drained_status got %h expected 00000608", rd);
    end
  endtask

  task automatic test_byte_enable();
    bus(1'b1, 0, 32'h0, 4'hF, 3'd0, rd, er, rv, ri);
    bus(1'b1, 0, 32'hFFFFFFFF, 4'b0010, 3'd0, rd, er, rv, ri);
    bus(1'b0, 0, 0, 4'hF, 3'd0, rd, er, rv, ri);
    checks++;
    if (rd !== 32'h0000FF00) begin
      errors++;
      $display("FAIL byte_enable got %h expected 0000ff00", rd);
    end
  endtask

  task automatic test_errors();
    bus(1'b0, 9, 0, 4'hF, 3'd2, rd, er, rv, ri);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || rv !== 1'b1) begin
      errors++;
      $display("FAIL unmapped_read got err=%b rdata=%h rvalid=%b expected 1 0 1", er, rd, rv);
    end
    bus(1'b1, 4, 32'hFFFFFFFF, 4'hF, 3'd3, rd, er, rv, ri);
    checks++;
    if (er !== 1'b1) begin
      errors++; $display("FAIL status_write_err got err=%b expected 1", er);
    end
    bus(1'b1, 5, 32'hFFFFFFFF, 4'hF, 3'd3, rd, er, rv, ri);
    checks++;
    if (er !== 1'b1) begin
      errors++; $display("FAIL result_write_err got err=%b expected 1", er);
    end
    bus(1'b0, 3, 0, 4'hF, 3'd0, rd, er, rv, ri);
    checks++;
    if (er !== 1'b0 || rd !== 32'h0) begin
      errors++; $display("FAIL op_read got err=%b rdata=%h expected 0 0", er, rd);
    end
    bus(1'b0, 4, 0, 4'hF, 3'd0, rd, er, rv, ri);
    checks++;
    if (rd !== 32'h0608 || er !== 1'b0) begin
      errors++; $display("FAIL status_unchanged got %h err=%b expected 00000608 0", rd, er);
    end
    bus(1'b0, 5, 0, 4'hF, 3'd0, rd, er, rv, ri);
    checks++;
    if (rd !== 32'd103) begin
      errors++; $display("FAIL result_unchanged got %h expected 00000067", rd);
    end
  endtask

  task automatic test_last_err();
    bus(1'b1, 3, 32'h2, 4'hF, 3'd0, rd, er, rv, ri);
    complete(1'b0, 64'h99);
    bus(1'b0, 4, 0, 4'hF, 3'd0, rd, er, rv, ri);
    checks++;
    if (rd !== 32'h070C) begin
      errors++; $display("FAIL last_err_status got %h expected 0000070c", rd);
    end
    bus(1'b1, 3, 32'h3, 4'hF, 3'd0, rd, er, rv, ri);
    // Result read granted in the same cycle as a completion.
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 8'd20; aid_i = 3'd1;
    ready_in = 1'b1; op_succ_in = 1'b1; value_in = 64'hAA;
    @(posedge clk); #1;
    req_i = 1'b0; ready_in = 1'b0;
    checks++;
    if (rdata_o !== 32'h99 || rvalid_o !== 1'b1) begin
      errors++;
      $display("FAIL race_old_value got rdata=%h rvalid=%b expected 99 1", rdata_o, rvalid_o);
    end
    bus(1'b0, 4, 0, 4'hF, 3'd0, rd, er, rv, ri);
    checks++;
    if (rd !== 32'h0808) begin
      errors++; $display("FAIL race_status got %h expected 00000808", rd);
    end
    bus(1'b0, 5, 0, 4'hF, 3'd0, rd, er, rv, ri);
    checks++;
    if (rd !== 32'hAA) begin
      errors++; $display("FAIL race_new_value got %h expected 000000aa", rd);
    end
  endtask

  task automatic test_reset_mid();
    bus(1'b1, 3, 32'h1, 4'hF, 3'd0, rd, er, rv, ri);
    bus(1'b1, 3, 32'h2, 4'hF, 3'd0, rd, er, rv, ri);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (cmd_valid_out !== 1'b0 || operation_out !== 3'd0 || key_out !== 32'h0 ||
        value_out !== 64'h0) begin
      errors++;
      $display("FAIL mid_reset_head got v=%b op=%0d key=%h val=%h expected all 0",
               cmd_valid_out, operation_out, key_out, value_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int w = 0; w <= 6; w++) begin
      bus(1'b0, w, 0, 4'hF, 3'd0, rd, er, rv, ri);
      checks++;
      if (rd !== 32'h0 || er !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_word%0d got %h err=%b expected 0 0", w, rd, er);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_commit();
    test_full();
    test_byte_enable();
    test_errors();
    test_last_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
